// File: rtl/psum_drain_writer_pkg.sv
// Shared definitions for the psum drain writer: default geometry of the
// eyeriss array and convolution, derivation helpers for the ofmap shape and
// per-column row stride, the psum data type and the drain FSM state type.
package psum_drain_writer_pkg;

  localparam int unsigned IMAGE_HEIGHT = 28;
  localparam int unsigned IMAGE_WIDTH  = 28;
  localparam int unsigned KERNEL       = 5;
  localparam int unsigned ARRAY_HEIGHT = 5;
  localparam int unsigned ARRAY_WIDTH  = 6;
  localparam int unsigned DATA_WIDTH   = 16;

  // Valid-convolution output size along one dimension.
  function automatic int unsigned out_dim(input int unsigned image,
                                          input int unsigned kernel);
    return image - kernel + 1;
  endfunction

  // Ofmap-row step between successive rows produced by one PE column.
  function automatic int unsigned row_stride(input int unsigned arr_h,
                                             input int unsigned arr_w,
                                             input int unsigned kernel);
    return arr_h + arr_w - 1 + 1 - kernel;
  endfunction

  typedef logic [DATA_WIDTH-1:0] psum_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } drain_state_e;

endpackage

// File: rtl/psum_drain_writer_if.sv
// Bus between the psum FIFO bank / ofmap BRAM and the drain writer.
// Signal names are seen from the drain writer (master) side:
//   psum_empty_i  per-column FIFO empty (FWFT)
//   psum_i        per-column FIFO head data
//   psum_rd_en_o  per-column pop strobe, one-hot or zero
//   ofmap_wr_*_o  ofmap BRAM write port (enable, linear address, data)
interface psum_drain_writer_if #(
  parameter int unsigned AW     = 6,
  parameter int unsigned DW     = 16,
  parameter int unsigned ADDR_W = 10
) ();
  logic [0:AW-1]         psum_empty_i;
  logic [0:AW-1][DW-1:0] psum_i;
  logic [0:AW-1]         psum_rd_en_o;
  logic                  ofmap_wr_en_o;
  logic [ADDR_W-1:0]     ofmap_wr_addr_o;
  logic [DW-1:0]         ofmap_wr_data_o;

  modport master (
    input  psum_empty_i, psum_i,
    output psum_rd_en_o, ofmap_wr_en_o, ofmap_wr_addr_o, ofmap_wr_data_o
  );

  modport slave (
    output psum_empty_i, psum_i,
    input  psum_rd_en_o, ofmap_wr_en_o, ofmap_wr_addr_o, ofmap_wr_data_o
  );
endinterface

// File: rtl/psum_drain_writer_rr_arbiter.sv
// Round-robin arbiter: grants the first requesting input at or after the
// pointer, combinationally; the pointer moves past the winner on a grant.
//   clk_i, rst_ni  clock, async active-low reset (pointer -> 0)
//   req_i          request per input
//   grant_o        one-hot grant or zero
//   idx_o          index of the granted input (valid with valid_o)
//   valid_o        a grant is issued this cycle
module psum_drain_writer_rr_arbiter #(
  parameter int unsigned N  = 6,
  parameter int unsigned IW = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [0:N-1]  req_i,
  output logic [0:N-1]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [IW-1:0] ptr;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!valid_o && req_i[(32'(ptr) + k) % N]) begin
        grant_o[(32'(ptr) + k) % N] = 1'b1;
        idx_o   = IW'((32'(ptr) + k) % N);
        valid_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr <= '0;
    end else if (valid_o) begin
      ptr <= (32'(idx_o) == N - 1) ? '0 : idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/psum_drain_writer.sv
// Drains the per-column psum FIFOs of the PE array and writes every ofmap
// pixel into the ofmap BRAM at linear address row*OUT_WIDTH+col.
//   clk_i, rst_ni  clock, async active-low reset
//   start_i        1-cycle pulse: clear counters and (re)start the drain
//   bus            master side of psum_drain_writer_if (FIFO pops, BRAM writes)
//   busy_o         draining
//   done_o         all OUT_HEIGHT*OUT_WIDTH pixels written, until next start
//   overflow_o     sticky: a popped pixel fell below the last ofmap row
module psum_drain_writer
  import psum_drain_writer_pkg::*;
#(
  parameter int unsigned G_ARRAY_WIDTH      = ARRAY_WIDTH,
  parameter int unsigned G_ROW_STRIDE       = row_stride(ARRAY_HEIGHT, ARRAY_WIDTH, KERNEL),
  parameter int unsigned G_OUT_HEIGHT       = out_dim(IMAGE_HEIGHT, KERNEL),
  parameter int unsigned G_OUT_WIDTH        = out_dim(IMAGE_WIDTH, KERNEL),
  parameter int unsigned G_DATA_WIDTH       = DATA_WIDTH,
  parameter int unsigned G_OFMAP_ADDR_WIDTH = 10
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  psum_drain_writer_if.master bus,
  output logic                busy_o,
  output logic                done_o,
  output logic                overflow_o
);

  localparam int unsigned N_PIX = G_OUT_HEIGHT * G_OUT_WIDTH;
  localparam int unsigned IW    = (G_ARRAY_WIDTH > 1) ? $clog2(G_ARRAY_WIDTH) : 1;
  localparam int unsigned CW    = $clog2(G_OUT_WIDTH + 1);
  localparam int unsigned PW    = $clog2(N_PIX + 1);
  localparam int unsigned RW    = $clog2(G_OUT_HEIGHT + G_ROW_STRIDE + G_ARRAY_WIDTH);
  localparam int unsigned ADW   = G_OFMAP_ADDR_WIDTH;

  drain_state_e state;

  // Per-column mapping state. row_base/addr_base hold c + row_cnt*STRIDE and
  // that row times OUT_WIDTH, advanced by addition instead of multiplying.
  logic [CW-1:0]  col_cnt   [G_ARRAY_WIDTH];
  logic [RW-1:0]  row_base  [G_ARRAY_WIDTH];
  logic [ADW-1:0] addr_base [G_ARRAY_WIDTH];
  logic [PW-1:0]  pix_cnt;

  logic                     pop_en;
  logic [0:G_ARRAY_WIDTH-1] req;
  logic [0:G_ARRAY_WIDTH-1] grant;
  logic [IW-1:0]            gidx;
  logic                     gvalid;
  logic                     sel_in_range;
  logic [G_DATA_WIDTH-1:0]  sel_data;

  // Pops stop once every pixel has been written, so the cycle spent moving
  // to DONE cannot steal a pixel belonging to the next run.
  assign pop_en = (state == ST_RUN) && !start_i && (pix_cnt != PW'(N_PIX));

  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < G_ARRAY_WIDTH; i++) begin
      req[i] = pop_en && !bus.psum_empty_i[i];
    end
  end

  psum_drain_writer_rr_arbiter #(
    .N  (G_ARRAY_WIDTH),
    .IW (IW)
  ) u_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (req),
    .grant_o (grant),
    .idx_o   (gidx),
    .valid_o (gvalid)
  );

  assign bus.psum_rd_en_o = grant;
  assign sel_in_range     = row_base[gidx] < RW'(G_OUT_HEIGHT);
  assign sel_data         = bus.psum_i[gidx];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state               <= ST_IDLE;
      busy_o              <= 1'b0;
      done_o              <= 1'b0;
      overflow_o          <= 1'b0;
      pix_cnt             <= '0;
      bus.ofmap_wr_en_o   <= 1'b0;
      bus.ofmap_wr_addr_o <= '0;
      bus.ofmap_wr_data_o <= '0;
      for (int unsigned i = 0; i < G_ARRAY_WIDTH; i++) begin
        col_cnt[i]   <= '0;
        row_base[i]  <= RW'(i);
        addr_base[i] <= ADW'(i * G_OUT_WIDTH);
      end
    end else begin
      bus.ofmap_wr_en_o <= 1'b0;

      if (gvalid) begin
        bus.ofmap_wr_addr_o <= addr_base[gidx] + ADW'(col_cnt[gidx]);
        bus.ofmap_wr_data_o <= sel_data;
        if (sel_in_range) begin
          bus.ofmap_wr_en_o <= 1'b1;
          pix_cnt           <= pix_cnt + 1'b1;
        end else begin
          overflow_o <= 1'b1;
        end
        // Row advance saturates once past the ofmap: every later pop of the
        // column stays out of range and the base registers cannot wrap.
        if (col_cnt[gidx] == CW'(G_OUT_WIDTH - 1)) begin
          col_cnt[gidx] <= '0;
          if (sel_in_range) begin
            row_base[gidx]  <= row_base[gidx] + RW'(G_ROW_STRIDE);
            addr_base[gidx] <= addr_base[gidx] + ADW'(G_ROW_STRIDE * G_OUT_WIDTH);
          end
        end else begin
          col_cnt[gidx] <= col_cnt[gidx] + 1'b1;
        end
      end

      if (start_i) begin
        state      <= ST_RUN;
        busy_o     <= 1'b1;
        done_o     <= 1'b0;
        overflow_o <= 1'b0;
        pix_cnt    <= '0;
        for (int unsigned i = 0; i < G_ARRAY_WIDTH; i++) begin
          col_cnt[i]   <= '0;
          row_base[i]  <= RW'(i);
          addr_base[i] <= ADW'(i * G_OUT_WIDTH);
        end
      end else begin
        case (state)
          ST_RUN: begin
            if (pix_cnt == PW'(N_PIX)) begin
              state  <= ST_DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_psum_drain_writer.sv
`timescale 1ns/1ps
module tb_psum_drain_writer;
  import psum_drain_writer_pkg::*;

  localparam int unsigned AW      = 6;
  localparam int unsigned DW      = 16;
  localparam int unsigned ADW     = 10;
  localparam int unsigned OUT_H   = 24;
  localparam int unsigned OUT_W   = 24;
  localparam int unsigned STRIDE  = 6;
  localparam int unsigned NPIX    = OUT_H * OUT_W;
  localparam int unsigned COL_PIX = NPIX / AW;

  typedef struct { psum_t data; bit inrange; } ent_t;
  typedef struct { logic [ADW-1:0] addr; psum_t data; } exp_t;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic start_i;
  logic busy_o, done_o, overflow_o;

  psum_drain_writer_if #(.AW(AW), .DW(DW), .ADDR_W(ADW)) bus ();

  psum_drain_writer #(
    .G_ARRAY_WIDTH      (AW),
    .G_ROW_STRIDE       (STRIDE),
    .G_OUT_HEIGHT       (OUT_H),
    .G_OUT_WIDTH        (OUT_W),
    .G_DATA_WIDTH       (DW),
    .G_OFMAP_ADDR_WIDTH (ADW)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .bus        (bus),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .overflow_o (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0;
  int          failures = 0;
  ent_t        fifo_q [AW][$];
  exp_t        exp_q  [AW][$];
  int unsigned push_k [AW];
  bit          pend_wr = 1'b0;
  int unsigned pend_col = 0;
  int unsigned wr_count = 0;
  logic [31:0] last_addr = '0;
  bit          log_en = 1'b0;
  int          pop_log [$];
  exp_t        mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // FIFO bank model: drives empty/head from the queues, pops on rd_en.
  task automatic refresh();
    for (int unsigned c = 0; c < AW; c++) begin
      if (fifo_q[c].size() != 0) begin
        bus.psum_empty_i[c] = 1'b0;
        bus.psum_i[c]       = fifo_q[c][0].data;
      end else begin
        bus.psum_empty_i[c] = 1'b1;
        bus.psum_i[c]       = '0;
      end
    end
  endtask

  // Reference mapping: k-th pixel of column c lands at
  // row = c + (k / OUT_W) * STRIDE, col = k % OUT_W.
  task automatic push(input int unsigned c, input psum_t d);
    int unsigned k, row, col;
    ent_t e;
    k   = push_k[c];
    row = c + (k / OUT_W) * STRIDE;
    col = k % OUT_W;
    e.data    = d;
    e.inrange = (row < OUT_H);
    if (e.inrange) exp_q[c].push_back('{addr: ADW'(row * OUT_W + col), data: d});
    fifo_q[c].push_back(e);
    push_k[c]++;
  endtask

  task automatic flush();
    for (int unsigned c = 0; c < AW; c++) begin
      fifo_q[c].delete();
      exp_q[c].delete();
      push_k[c] = 0;
    end
    pend_wr  = 1'b0;
    wr_count = 0;
    refresh();
  endtask

  function automatic bit fifos_empty();
    for (int unsigned c = 0; c < AW; c++) if (fifo_q[c].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step();
    @(negedge clk_i);
    #2;
  endtask

  task automatic pulse_start(input bit clear_model);
    if (clear_model) begin
      for (int unsigned c = 0; c < AW; c++) push_k[c] = 0;
      wr_count = 0;
    end
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int unsigned i = 0; i < 3000; i++) begin
      step();
      if (fifos_empty() && !pend_wr) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: drain timeout got pending expected none", name);
    end
    step();
    step();
  endtask

  initial begin : fifo_model
    logic [0:AW-1] rd;
    ent_t          e;
    int            pop_col;
    forever begin
      @(negedge clk_i);
      #4;
      rd = bus.psum_rd_en_o;
      @(posedge clk_i);
      #1;
      chk("rd_onehot0", 32'($onehot0(rd)), 32'd1);
      pend_wr = 1'b0;
      pop_col = -1;
      for (int unsigned c = 0; c < AW; c++) begin
        if (rd[c]) begin
          pop_col = int'(c);
          checks++;
          if (fifo_q[c].size() == 0) begin
            failures++;
            $display("FAIL pop_empty: got pop on empty col %0d expected no pop", c);
          end else begin
            e        = fifo_q[c].pop_front();
            pend_wr  = e.inrange;
            pend_col = c;
          end
        end
      end
      if (log_en) pop_log.push_back(pop_col);
      refresh();
    end
  end

  // Monitor: every cycle the write strobe must follow the previous pop, and
  // each write must match the next expected pixel of the popped column.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      chk("wr_en_latency", 32'(bus.ofmap_wr_en_o), 32'(pend_wr));
      if (bus.ofmap_wr_en_o && pend_wr) begin
        checks++;
        if (exp_q[pend_col].size() == 0) begin
          failures++;
          $display("FAIL wr_unexpected: got addr %0d expected no write", bus.ofmap_wr_addr_o);
        end else begin
          mon_e = exp_q[pend_col].pop_front();
          chk("wr_addr", 32'(bus.ofmap_wr_addr_o), 32'(mon_e.addr));
          chk("wr_data", 32'(bus.ofmap_wr_data_o), 32'(mon_e.data));
        end
        wr_count++;
        last_addr = 32'(bus.ofmap_wr_addr_o);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int          exp_arb [7] = '{0, 1, 2, 3, 4, 5, 0};
    int unsigned total, c, remain;
    rst_ni  = 1'b0;
    start_i = 1'b0;
    flush();
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_wr_en",    32'(bus.ofmap_wr_en_o),   32'd0);
    chk("rst_rd_en",    32'(bus.psum_rd_en_o),    32'd0);
    chk("rst_wr_addr",  32'(bus.ofmap_wr_addr_o), 32'd0);
    chk("rst_busy",     32'(busy_o),              32'd0);
    chk("rst_done",     32'(done_o),              32'd0);
    chk("rst_overflow", 32'(overflow_o),          32'd0);
    #1;
    rst_ni = 1'b1;

    // Arbitration: all columns non-empty before the drain starts.
    for (int unsigned i = 0; i < 2 * AW; i++) push(i % AW, psum_t'($urandom));
    step();
    step();
    chk("idle_no_pop", 32'(fifo_q[0].size()), 32'd2);
    pop_log.delete();
    pulse_start(1'b0);
    log_en = 1'b1;
    repeat (9) step();
    log_en = 1'b0;
    chk("arb_log_len", 32'(pop_log.size() >= 7), 32'd1);
    for (int unsigned i = 0; i < 7; i++) begin
      if (i < pop_log.size()) chk("arb_grant", 32'(pop_log[i]), 32'(exp_arb[i]));
    end
    wait_drain("arb_drain");

    // Single column 3, then column 0 row wrap, then column 5 overflow.
    pulse_start(1'b1);
    for (int unsigned k = 0; k < OUT_W; k++) push(3, psum_t'(k));
    wait_drain("col3_drain");
    chk("col3_count", wr_count, 32'd24);
    chk("col3_last_addr", last_addr, 32'd95);
    for (int unsigned k = 0; k < 2 * OUT_W; k++) push(0, psum_t'($urandom));
    wait_drain("col0_drain");
    chk("col0_count", wr_count, 32'd72);
    chk("col0_last_addr", last_addr, 32'd167);
    for (int unsigned k = 0; k < COL_PIX; k++) push(5, psum_t'($urandom));
    wait_drain("col5_drain");
    chk("col5_no_overflow", 32'(overflow_o), 32'd0);
    chk("col5_last_addr", last_addr, 32'd575);
    push(5, psum_t'($urandom));
    wait_drain("col5_ovf_drain");
    chk("overflow_set", 32'(overflow_o), 32'd1);
    chk("overflow_pix_cnt", wr_count, 32'd168);
    chk("overflow_busy", 32'(busy_o), 32'd1);

    // Restart mid-run after 100 writes.
    pulse_start(1'b1);
    chk("restart_ovf_clear", 32'(overflow_o), 32'd0);
    for (int unsigned i = 0; i < 100; i++) push(i % AW, psum_t'($urandom));
    wait_drain("mid_drain");
    chk("mid_count", wr_count, 32'd100);
    chk("mid_busy", 32'(busy_o), 32'd1);
    pulse_start(1'b1);
    push(0, psum_t'($urandom));
    wait_drain("restart_drain");
    chk("restart_addr", last_addr, 32'd0);

    // Asynchronous reset in the middle of a busy drain.
    for (int unsigned i = 0; i < 30; i++) push($urandom_range(0, AW - 1), psum_t'($urandom));
    repeat (3) step();
    rst_ni = 1'b0;
    #1;
    chk("arst_wr_en", 32'(bus.ofmap_wr_en_o), 32'd0);
    chk("arst_rd_en", 32'(bus.psum_rd_en_o),  32'd0);
    chk("arst_busy",  32'(busy_o),            32'd0);
    chk("arst_done",  32'(done_o),            32'd0);
    flush();
    step();
    step();
    rst_ni = 1'b1;
    step();

    // Full frame with random data, random column order.
    pulse_start(1'b1);
    total = 0;
    while (total < NPIX) begin
      for (int unsigned n = 0; n < 3; n++) begin
        c = $urandom_range(0, AW - 1);
        if (push_k[c] < COL_PIX) begin
          push(c, psum_t'($urandom));
          total++;
        end
      end
      step();
    end
    remain = 1;
    for (int unsigned i = 0; i < 4000; i++) begin
      @(negedge clk_i);
      #1;
      if (wr_count == NPIX) begin
        remain = 0;
        break;
      end
    end
    chk("full_reached", remain, 32'd0);
    chk("full_done_not_yet", 32'(done_o), 32'd0);
    @(negedge clk_i);
    #1;
    chk("full_done", 32'(done_o), 32'd1);
    chk("full_busy_low", 32'(busy_o), 32'd0);
    chk("full_overflow", 32'(overflow_o), 32'd0);
    #1;
    push(0, psum_t'($urandom));
    repeat (5) step();
    chk("done_no_pop", 32'(fifo_q[0].size()), 32'd1);
    chk("done_hold", 32'(done_o), 32'd1);
    total = 0;
    for (int unsigned i = 0; i < AW; i++) total += exp_q[i].size();
    chk("all_written", total, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
